// File: rtl/random_range_arbiter.sv
// Round-robin arbiter sharing one 32-bit Galois LFSR among NUM requesters.
// Each grant returns a value in [lo, hi] plus a PX-percent Bernoulli bit.
module random_range_arbiter #(
  parameter int          NUM  = 4,
  parameter int          DW   = 10,
  parameter logic [31:0] SEED = 32'hACE1_2468,
  parameter int          PX   = 67
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [NUM-1:0]          req,
  input  logic [NUM*DW-1:0]       lo,
  input  logic [NUM*DW-1:0]       hi,
  output logic [NUM-1:0]          ack,
  output logic                    rd_valid,
  output logic [DW-1:0]           rd_data,
  output logic [$clog2(NUM)-1:0]  rd_id,
  output logic                    prob_b,
  output logic                    rd_err
);

  localparam int          IW    = $clog2(NUM);
  localparam int          PW    = 17 + DW;
  localparam logic [31:0] SEED0 = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] TAPS  = 32'h8020_0003;
  localparam logic [6:0]  PXV   = 7'(PX);
  localparam logic [IW-1:0] LAST = IW'(NUM - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]    state;
  logic [31:0]   lfsr;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id_q;
  logic [IW-1:0] win;
  logic [IW-1:0] j;
  logic          found;
  logic [DW-1:0] lo_q;
  logic [DW-1:0] hi_q;
  logic [PW-1:0] prod_q;
  logic [22:0]   pq_q;
  logic          err_q;
  logic [DW-1:0] data_q;
  logic [IW-1:0] rid_q;
  logic          prob_q;
  logic [DW:0]   span;
  logic [DW:0]   sum;
  logic [DW-1:0] data_n;
  logic          prob_n;
  logic          unused;
  int            idx;

  // First set request at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    j     = '0;
    for (int k = 0; k < NUM; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM) idx = idx - NUM;
      j = IW'(idx);
      if (!found && req[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
  end

  assign span   = {1'b0, hi_q} - {1'b0, lo_q} + (DW+1)'(1);
  assign sum    = {1'b0, lo_q} + prod_q[16+DW:16];
  assign data_n = err_q ? lo_q : sum[DW-1:0];
  assign prob_n = pq_q[22:16] < PXV;
  assign unused = ^{prod_q[15:0], pq_q[15:0], sum[DW]};

  // Results are live during OUT and held afterwards.
  assign rd_valid = (state == OUT);
  assign ack      = rd_valid ? (NUM'(1) << id_q) : '0;
  assign rd_err   = rd_valid & err_q;
  assign rd_data  = rd_valid ? data_n : data_q;
  assign rd_id    = rd_valid ? id_q : rid_q;
  assign prob_b   = rd_valid ? prob_n : prob_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lfsr   <= SEED0;
      ptr    <= '0;
      id_q   <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      prod_q <= '0;
      pq_q   <= '0;
      err_q  <= 1'b0;
      data_q <= '0;
      rid_q  <= '0;
      prob_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            id_q  <= win;
            lo_q  <= lo[int'(win)*DW +: DW];
            hi_q  <= hi[int'(win)*DW +: DW];
            state <= CALC;
          end
        end
        CALC: begin
          prod_q <= PW'(lfsr[15:0]) * PW'(span);
          pq_q   <= 23'(lfsr[31:16]) * 23'd100;
          err_q  <= hi_q < lo_q;
          state  <= OUT;
        end
        OUT: begin
          data_q <= data_n;
          rid_q  <= id_q;
          prob_q <= prob_n;
          ptr    <= (id_q == LAST) ? '0 : id_q + IW'(1);
          lfsr   <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
